coriolis_ker1_xn_fifo: RTL

//  Elastic stream FIFO directly downstream of the coriolis ker1 subker0 node.
//  - Consumes the xn stream (out1/ovalid/oready) and re-presents it to the next subkernel or stream sink.
//  - Decouples the subker0 pipeline from consumer back-pressure.
//  - Absorbs up to DEPTH words, so short consumer stalls do not freeze the subker0 datapath.

---
 rtl/coriolis_ker1_xn_fifo.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/coriolis_ker1_xn_fifo.sv
// Elastic first-word-fall-through FIFO for the coriolis ker1 xn stream (DEPTH-1 RAM words + output register).
// Optional occupancy high-water mark port `hwm` is built when XN_FIFO_HWM_EN is defined.
module coriolis_ker1_xn_fifo #(
    parameter int STREAMW = 34,
    parameter int DEPTH   = 16,
    parameter int AW      = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STREAMW-1:0] in1,
    input  logic               ivalid_in1,
    output logic               iready,
    output logic [STREAMW-1:0] out1,
    output logic               ovalid,
    input  logic               oready,
    output logic [AW:0]        count
`ifdef XN_FIFO_HWM_EN
    ,
    output logic [AW:0]        hwm
`endif
);

    localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL  = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ALMOST = (AW+1)'(DEPTH - 1);
    localparam logic [AW-1:0] PTR_LAST  = AW'(DEPTH - 2);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        MID   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state, state_next;

    logic [STREAMW-1:0] mem [0:DEPTH-2];
    logic [AW-1:0]      rd_ptr, wr_ptr;
    logic [AW-1:0]      rd_ptr_next, wr_ptr_next;
    logic [AW:0]        count_next;
    logic               push, pop;
    logic               ram_has_data;
    logic               ram_we;
    logic               out_load_in;
    logic               out_load_ram;
    logic               ovalid_next;

    // Pointers cycle over the DEPTH-1 RAM slots, not over a power of two.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + AW'(1);
    endfunction

    assign push         = ivalid_in1 & iready;
    assign pop          = ovalid & oready;
    assign ram_has_data = (count > CNT_ONE);

    always_comb begin
        state_next   = state;
        count_next   = count;
        ram_we       = 1'b0;
        out_load_in  = 1'b0;
        out_load_ram = 1'b0;
        ovalid_next  = ovalid;

        case (state)
            EMPTY: begin
                if (push) begin
                    out_load_in = 1'b1;
                    ovalid_next = 1'b1;
                    count_next  = CNT_ONE;
                    state_next  = MID;
                end
            end
            MID: begin
                if (push && !pop) begin
                    ram_we     = 1'b1;
                    count_next = count + CNT_ONE;
                    if (count == CNT_ALMOST) begin
                        state_next = FULL;
                    end
                end else if (pop && !push) begin
                    count_next = count - CNT_ONE;
                    if (ram_has_data) begin
                        out_load_ram = 1'b1;
                    end else begin
                        ovalid_next = 1'b0;
                        state_next  = EMPTY;
                    end
                end else if (push && pop) begin
                    // With only the output register occupied the new word skips the RAM.
                    if (ram_has_data) begin
                        ram_we       = 1'b1;
                        out_load_ram = 1'b1;
                    end else begin
                        out_load_in = 1'b1;
                    end
                end
            end
            FULL: begin
                if (pop) begin
                    out_load_ram = 1'b1;
                    count_next   = CNT_ALMOST;
                    state_next   = MID;
                end
            end
            default: begin
                state_next  = EMPTY;
                count_next  = '0;
                ovalid_next = 1'b0;
            end
        endcase
    end

    assign rd_ptr_next = out_load_ram ? ptr_inc(rd_ptr) : rd_ptr;
    assign wr_ptr_next = ram_we       ? ptr_inc(wr_ptr) : wr_ptr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= EMPTY;
            count  <= '0;
            iready <= 1'b0;
            ovalid <= 1'b0;
            out1   <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            state  <= state_next;
            count  <= count_next;
            iready <= (count_next < CNT_FULL);
            ovalid <= ovalid_next;
            rd_ptr <= rd_ptr_next;
            wr_ptr <= wr_ptr_next;
            if (out_load_in) begin
                out1 <= in1;
            end else if (out_load_ram) begin
                out1 <= mem[rd_ptr];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[wr_ptr] <= in1;
        end
    end

`ifdef XN_FIFO_HWM_EN
    // count_next never exceeds DEPTH, so the mark saturates there naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hwm <= '0;
        end else if (count_next > hwm) begin
            hwm <= count_next;
        end
    end
`endif

endmodule
